// File: rtl/offset_add_pipe.sv
// Two-stage valid/ready pipeline adding a selectable offset to 8-bit samples.
// Also keeps a saturating count of delivered results whose sum carried out.
module offset_add_pipe #(
  parameter int unsigned P = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [1:0] in_sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_carry,
  output logic [1:0] out_sel,
  input  logic       cnt_clr,
  output logic [7:0] carry_cnt
);

  localparam logic [7:0] OFF_K  = 8'd42;
  localparam logic [7:0] OFF_P  = P[7:0];
  localparam logic [7:0] OFF_PK = 8'(P + 42);

  logic       s1_valid;
  logic [7:0] s1_data;
  logic [1:0] s1_sel;
  logic       en1;
  logic       en2;
  logic [7:0] off;
  logic [8:0] sum;

  assign en2      = !out_valid || out_ready;
  assign en1      = !s1_valid || en2;
  assign in_ready = en1;

  always_comb begin
    off = 8'd0;
    unique case (s1_sel)
      2'd0: off = OFF_K;
      2'd1: off = OFF_PK;
      2'd2: off = OFF_P;
      2'd3: off = 8'd0;
    endcase
  end

  assign sum = {1'b0, s1_data} + {1'b0, off};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= 8'd0;
      s1_sel   <= 2'd0;
    end else if (en1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_sel  <= in_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_carry <= 1'b0;
      out_sel   <= 2'd0;
    end else if (en2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= sum[7:0];
        out_carry <= sum[8];
        out_sel   <= s1_sel;
      end
    end
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt <= 8'd0;
    end else if (cnt_clr) begin
      carry_cnt <= 8'd0;
    end else if (out_valid && out_ready && out_carry
                 && carry_cnt != 8'hFF) begin
      carry_cnt <= carry_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_offset_add_pipe.sv
// Self-checking bench for offset_add_pipe: directed table, corner
// sequences, and a random valid/ready run against a queue model.
module tb_offset_add_pipe;

  localparam int P = 23;
  localparam int NRAND = 10000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_carry;
  logic [1:0] out_sel;
  logic       cnt_clr;
  logic [7:0] carry_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  offset_add_pipe #(.P(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_sel   (out_sel),
    .cnt_clr   (cnt_clr),
    .carry_cnt (carry_cnt)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] s;
    logic [7:0] ed;
    logic       ec;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [8:0] ref_sum(input logic [7:0] d,
                                         input logic [1:0] s);
    int off;
    case (s)
      2'd0:    off = 42;
      2'd1:    off = (P + 42) % 256;
      2'd2:    off = P;
      default: off = 0;
    endcase
    return 9'(int'(d) + off);
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  // One isolated sample: checks exact 2-edge latency and counter update.
  task automatic send_one(input logic [7:0] d, input logic [1:0] s,
                          input logic [7:0] ed, input logic ec,
                          input logic clr);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_sel = s; out_ready = 1'b1;
    #1 chk("one_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("one_lat1_valid", out_valid, 0);
    @(negedge clk);
    cnt_clr = clr;
    chk("one_valid", out_valid, 1);
    chk("one_data", out_data, ed);
    chk("one_carry", out_carry, ec);
    chk("one_sel", out_sel, s);
    if (clr) exp_cnt = 0;
    else if (ec) exp_cnt = sat_inc(exp_cnt);
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("one_bubble", out_valid, 0);
    chk("one_cnt", carry_cnt, exp_cnt);
  endtask

  initial begin
    logic [10:0] sb[$];
    logic [10:0] front;
    logic        hold;
    int          sent;
    int          rcv;
    int          cyc;
    int          vcount;

    vecs[0] = '{8'h10, 2'd0, 8'h3A, 1'b0};
    vecs[1] = '{8'hF0, 2'd1, 8'h31, 1'b1};
    vecs[2] = '{8'hF0, 2'd2, 8'h07, 1'b1};
    vecs[3] = '{8'hAB, 2'd3, 8'hAB, 1'b0};
    vecs[4] = '{8'hD6, 2'd0, 8'h00, 1'b1};
    vecs[5] = '{8'hFF, 2'd3, 8'hFF, 1'b0};
    vecs[6] = '{8'hE9, 2'd2, 8'h00, 1'b1};
    vecs[7] = '{8'h00, 2'd1, 8'h41, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_carry_cnt", carry_cnt, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_carry", out_carry, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++)
      send_one(vecs[i].d, vecs[i].s, vecs[i].ed, vecs[i].ec, 1'b0);

    // Backpressure: two samples fill the pipe, third waits.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h01; in_sel = 2'd3; out_ready = 1'b0;
    #1 chk("bp_rdy_a", in_ready, 1);
    @(negedge clk);
    in_data = 8'h02;
    #1 chk("bp_rdy_b", in_ready, 1);
    @(negedge clk);
    in_data = 8'h03;
    #1 chk("bp_rdy_c", in_ready, 0);
    chk("bp_hold_c", out_data, 8'h01);
    @(negedge clk);
    #1 chk("bp_rdy_d", in_ready, 0);
    chk("bp_hold_d", out_data, 8'h01);
    chk("bp_valid_d", out_valid, 1);
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp_rel_rdy", in_ready, 1);
    chk("bp_out1", out_data, 8'h01);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_out2", out_data, 8'h02);
    chk("bp_out2_v", out_valid, 1);
    @(negedge clk);
    chk("bp_out3", out_data, 8'h03);
    chk("bp_out3_v", out_valid, 1);
    @(negedge clk);
    chk("bp_drain", out_valid, 0);

    // Saturation with back-to-back throughput.
    vcount = 0;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
      in_valid = 1'b1; in_data = 8'hFF; in_sel = 2'd0; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (out_valid) vcount++;
    repeat (3) @(negedge clk);
    chk("thru_no_bubble", vcount, 259);
    chk("sat_cnt", carry_cnt, 255);

    // Reset with both stages holding carry results.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hFF; in_sel = 2'd0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_full_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", carry_cnt, 0);
    chk("mid_rst_rdy", in_ready, 1);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_stale", out_valid, 0);
    end
    send_one(8'h10, 2'd0, 8'h3A, 1'b0, 1'b0);

    // Clear beats a simultaneous increment.
    for (int i = 0; i < 3; i++)
      send_one(8'hF0, 2'd1, 8'h31, 1'b1, 1'b0);
    send_one(8'hF0, 2'd2, 8'h07, 1'b1, 1'b1);

    // Random traffic against the queue model.
    sent = 0; rcv = 0; cyc = 0; hold = 1'b0;
    while ((sent < NRAND || rcv < NRAND) && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      if (!hold) begin
        in_valid = (sent < NRAND) && ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
        in_sel   = 2'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 63) == 0);
      #1;
      chk("rnd_cnt", carry_cnt, exp_cnt);
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("rnd_spurious", 1, 0);
        end else begin
          front = sb[0];
          chk("rnd_out", {out_sel, out_carry, out_data}, front);
          if (out_ready) begin
            void'(sb.pop_front());
            rcv++;
          end
        end
      end
      if (cnt_clr) exp_cnt = 0;
      else if (out_valid && out_ready && out_carry)
        exp_cnt = sat_inc(exp_cnt);
      if (in_valid && in_ready) begin
        sb.push_back({in_sel, ref_sum(in_data, in_sel)});
        sent++;
        hold = 1'b0;
      end else begin
        hold = in_valid;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; cnt_clr = 1'b0;
    chk("rnd_all_recv", rcv, NRAND);
    chk("rnd_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/offset_add_pipe.md
OFFSET_ADD_PIPE -- requirements
Module: offset_add_pipe

Interface
REQ-001 Parameter P, default 23, base offset constant; valid range 0..255.
REQ-002 Port clk  input  1  single clock, all state on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port in_valid  input  1  upstream sample valid.
REQ-005 Port in_ready  output  1  block accepts sample this cycle.
REQ-006 Port in_data  input  8  sample value.
REQ-007 Port in_sel  input  2  offset select.
REQ-008 Port out_valid  output  1  result valid.
REQ-009 Port out_ready  input  1  downstream accepts result.
REQ-010 Port out_data  output  8  offset sum, modulo 256.
REQ-011 Port out_carry  output  1  bit 8 of 9-bit sum.
REQ-012 Port out_sel  output  2  in_sel carried with the sample.
REQ-013 Port cnt_clr  input  1  synchronous clear of carry_cnt.
REQ-014 Port carry_cnt  output  8  saturating count of accepted results with carry set.

Function
REQ-015 Offset per in_sel: 0 -> 42; 1 -> (P+42) mod 256; 2 -> P; 3 -> 0 (pass-through).
REQ-016 Sum computed at 9 bits: out_data = sum[7:0], out_carry = sum[8]; no saturation of data.
REQ-017 Two register stages: S1 captures in_data/in_sel; S2 holds out_data/out_carry/out_sel; each stage has its own valid bit; S2 valid drives out_valid.
REQ-018 Transfer on a port only when valid and ready are both high in the same cycle.
REQ-019 Advance enables: en2 = !out_valid | out_ready; en1 = !s1_valid | en2; in_ready = en1 (combinational path from out_ready to in_ready is permitted).
REQ-020 Latency: sample accepted in cycle N appears on out_valid in cycle N+2 when out_ready held high.
REQ-021 Throughput: one sample per cycle sustained with out_ready high; no bubbles inserted.
REQ-022 Backpressure: out_ready low holds out_data/out_carry/out_sel/out_valid stable; S1 fills, then in_ready drops; no sample dropped, duplicated or reordered.
REQ-023 Stage with valid low while its enable is high clears its valid bit (bubble propagates).
REQ-024 carry_cnt increments by 1 on each cycle with out_valid & out_ready & out_carry; holds at 255 (no wrap).
REQ-025 cnt_clr high sets carry_cnt to 0 next edge; clear wins over a simultaneous increment.
REQ-026 Data registers with valid low are don't-care; outputs qualified only by out_valid.

Reset
REQ-027 rst_n low asynchronously clears s1_valid, out_valid, carry_cnt to 0; out_data, out_carry, out_sel reset to 0.
REQ-028 in_ready reads 1 during and immediately after reset.
REQ-029 Reset mid-operation discards all in-flight samples; first sample after rst_n release follows REQ-020 latency.

Verification
REQ-030 P=23, out_ready=1: in_data=0x10 sel=0 -> cycle+2 out_data=0x3A, carry=0, out_sel=0.
REQ-031 P=23: in_data=0xF0 sel=1 (offset 0x41) -> out_data=0x31, carry=1, carry_cnt 0->1; sel=2 with 0xF0 -> 0x07, carry=1; sel=3 with 0xAB -> 0xAB, carry=0.
REQ-032 Backpressure: stream 0x01,0x02,0x03 sel=3 back-to-back, out_ready=0 for 4 cycles -> in_ready low after 2 accepted, out_data holds 0x01; on release outputs 0x01,0x02,0x03 in consecutive cycles.
REQ-033 Saturation: 260 accepted carry results -> carry_cnt=255; cnt_clr asserted same cycle as carry accept -> carry_cnt=0.
REQ-034 Reset mid-stream: rst_n pulsed low with both stages valid -> out_valid=0 and carry_cnt=0 immediately, no stale output after release.
REQ-035 Random valid/ready toggling, 10k samples, all sels -> output sequence equals scoreboard model of REQ-015/016 in order.
